// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement negator: copies bits up to and including the first 1
// of each LSB-first word, then inverts the rest. A bit counter re-arms it every WORD_W bits.
module serial_twos_complementer #(
  parameter int WORD_W   = 8,
  parameter int ST_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                stream,
  output logic                comp,
  output logic [ST_WIDTH-1:0] state,
  output logic                word_done
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_COPY   = 2'b00,
    S_INVERT = 2'b01
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic             invert;

  assign word_done = (bit_cnt == CNT_W'(WORD_W - 1));
  assign state     = ST_WIDTH'(state_q);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_COPY;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  // Illegal encodings fall into the default arm: behave as S_COPY and return there.
  always_comb begin
    state_d = S_COPY;
    invert  = 1'b0;
    case (state_q)
      S_COPY: begin
        invert  = 1'b0;
        state_d = stream ? S_INVERT : S_COPY;
      end
      S_INVERT: begin
        invert  = 1'b1;
        state_d = S_INVERT;
      end
      default: begin
        invert  = 1'b0;
        state_d = S_COPY;
      end
    endcase
    if (word_done) state_d = S_COPY;
  end

  assign comp = stream ^ invert;

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Bench for serial_twos_complementer: expected serial bits come from -word mod 2^WORD_W
// and are queued as each bit is driven, then popped against comp in the same cycle.
module tb_serial_twos_complementer;

  localparam int WORD_W   = 8;
  localparam int ST_WIDTH = 2;

  logic                clk = 1'b0;
  logic                rst_b;
  logic                stream;
  logic                comp;
  logic [ST_WIDTH-1:0] state;
  logic                word_done;

  logic [0:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  serial_twos_complementer #(.WORD_W(WORD_W), .ST_WIDTH(ST_WIDTH)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .stream    (stream),
    .comp      (comp),
    .state     (state),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  // Expected output bit i of the negated word.
  function automatic logic neg_bit(input logic [WORD_W-1:0] w, input int i);
    logic [WORD_W-1:0] n;
    n = -w;
    return n[i];
  endfunction

  // Expected state while bit i is on the line: S_INVERT once a lower bit was 1.
  function automatic logic [ST_WIDTH-1:0] exp_state(input logic [WORD_W-1:0] w, input int i);
    logic [WORD_W-1:0] m;
    m = (WORD_W'(1) << i) - WORD_W'(1);
    return ((w & m) != '0) ? ST_WIDTH'(1) : ST_WIDTH'(0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic e);
    stream = b;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic test_reset();
    logic [0:0] e;
    rst_b  = 1'b1;
    stream = 1'b0;
    step();
    step();
    drive_bit(1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (comp !== e) begin
      errors++;
      $display("FAIL reset_comp got %b expected %b", comp, e);
    end
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state got %b expected 00", state);
    end
    step();
    rst_b = 1'b0;
    stream = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_after state=%b word_done=%b expected 00/0", state, word_done);
    end
  endtask

  task automatic test_zero_word();
    logic [0:0] e;
    for (int i = 0; i < WORD_W; i++) begin
      drive_bit(1'b0, neg_bit('0, i));
      e = exp_q.pop_front();
      checks++;
      if (comp !== e || state !== 2'b00 || word_done !== (i == WORD_W - 1)) begin
        errors++;
        $display("FAIL zero_word bit%0d comp=%b state=%b done=%b expected %b/00/%b",
                 i, comp, state, word_done, e, (i == WORD_W - 1));
      end
      step();
    end
  endtask

  task automatic test_word_06();
    logic [0:0] e;
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] got;
    w = 8'h06;
    for (int i = 0; i < WORD_W; i++) begin
      drive_bit(w[i], neg_bit(w, i));
      e = exp_q.pop_front();
      got[i] = comp;
      checks++;
      if (comp !== e || state !== exp_state(w, i)) begin
        errors++;
        $display("FAIL word06 bit%0d comp=%b state=%b expected %b/%b",
                 i, comp, state, e, exp_state(w, i));
      end
      step();
    end
    checks++;
    if (got !== 8'hFA) begin
      errors++;
      $display("FAIL word06_value got %h expected fa", got);
    end
  endtask

  task automatic test_most_negative();
    logic [0:0] e;
    logic [WORD_W-1:0] w;
    w = 8'h80;
    for (int i = 0; i < WORD_W; i++) begin
      drive_bit(w[i], neg_bit(w, i));
      e = exp_q.pop_front();
      checks++;
      if (comp !== e || comp !== w[i]) begin
        errors++;
        $display("FAIL most_neg bit%0d comp=%b expected %b", i, comp, e);
      end
      step();
    end
    stream = 1'b0;
    #2;
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL most_neg_next_state got %b expected 00", state);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:0] e;
    logic [WORD_W-1:0] w;
    logic [2*WORD_W-1:0] got;
    w = 8'h01;
    for (int i = 0; i < 2 * WORD_W; i++) begin
      drive_bit(w[i % WORD_W], neg_bit(w, i % WORD_W));
      e = exp_q.pop_front();
      got[i] = comp;
      checks++;
      if (comp !== e || word_done !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL back_to_back cyc%0d comp=%b done=%b expected %b/%b",
                 i, comp, word_done, e, (i == 7 || i == 15));
      end
      step();
    end
    checks++;
    if (got !== 16'hFFFF) begin
      errors++;
      $display("FAIL back_to_back_value got %h expected ffff", got);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [0:0] e;
    logic [WORD_W-1:0] w;
    w = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      drive_bit(w[i], neg_bit(w, i));
      e = exp_q.pop_front();
      checks++;
      if (comp !== e || state !== exp_state(w, i)) begin
        errors++;
        $display("FAIL mid_reset_pre bit%0d comp=%b state=%b expected %b/%b",
                 i, comp, state, e, exp_state(w, i));
      end
      step();
    end
    rst_b  = 1'b1;
    stream = 1'b1;
    step();
    rst_b = 1'b0;
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_state got %b expected 00", state);
    end
    for (int i = 0; i < WORD_W; i++) begin
      drive_bit(w[i], neg_bit(w, i));
      e = exp_q.pop_front();
      checks++;
      if (comp !== e || word_done !== (i == WORD_W - 1)) begin
        errors++;
        $display("FAIL mid_reset_word bit%0d comp=%b done=%b expected %b/%b",
                 i, comp, word_done, e, (i == WORD_W - 1));
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [0:0] e;
    logic [WORD_W-1:0] w;
    int bad;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      w = WORD_W'($urandom_range(0, (1 << WORD_W) - 1));
      for (int i = 0; i < WORD_W; i++) begin
        drive_bit(w[i], neg_bit(w, i));
        e = exp_q.pop_front();
        checks++;
        if (comp !== e) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL random word%0d=%h bit%0d comp=%b expected %b", k, w, i, comp, e);
        end
        step();
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_b  = 1'b1;
    stream = 1'b0;
    test_reset();
    test_zero_word();
    test_word_06();
    test_most_negative();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
